// File: rtl/ctrl_exposure_time.sv
// Exposure-time setting driven by up/down buttons, with press-and-hold auto-repeat,
// saturation at the legal limits and a Lock input that freezes the setting.
module ctrl_exposure_time #(
  parameter int WIDTH        = 5,
  parameter int EXP_MIN      = 2,
  parameter int EXP_MAX      = 30,
  parameter int EXP_DEFAULT  = 10,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Exp_increase,
  input  logic             Exp_decrease,
  input  logic             Lock,
  output logic [WIDTH-1:0] EX_time,
  output logic             At_min,
  output logic             At_max,
  output logic             Changed
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(EXP_MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(EXP_MAX);
  localparam logic [WIDTH-1:0] DEF_V = WIDTH'(EXP_DEFAULT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  if (!(EXP_MIN <= EXP_DEFAULT && EXP_DEFAULT <= EXP_MAX &&
        EXP_MAX <= (2 ** WIDTH) - 1 && REPEAT_DELAY >= 1 && REPEAT_RATE >= 1)) begin : g_badParams
    $error("ctrl_exposure_time: inconsistent parameter set");
  end

  logic             r_prevInc;
  logic             r_prevDec;
  logic [1:0]       r_state;
  logic             r_dir;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_exTime;
  logic             r_atMin;
  logic             r_atMax;
  logic             r_changed;

  logic             w_riseInc;
  logic             w_riseDec;
  logic             w_held;
  logic             w_other;
  logic [1:0]       w_stateNext;
  logic             w_dirNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_stepUp;
  logic             w_stepDn;
  logic [WIDTH-1:0] w_exNext;

  assign w_riseInc = Exp_increase & ~r_prevInc;
  assign w_riseDec = Exp_decrease & ~r_prevDec;
  assign w_held    = (r_dir == DIR_DEC) ? Exp_decrease : Exp_increase;
  assign w_other   = (r_dir == DIR_DEC) ? Exp_increase : Exp_decrease;

  // A press with the opposite button already down is ignored, as is anything under Lock.
  always_comb begin
    w_stateNext = r_state;
    w_dirNext   = r_dir;
    w_cntNext   = r_cnt;
    w_stepUp    = 1'b0;
    w_stepDn    = 1'b0;
    if (Lock) begin
      w_stateNext = ST_IDLE;
      w_cntNext   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_riseInc && !Exp_decrease) begin
            w_stateNext = ST_DELAY;
            w_dirNext   = DIR_INC;
            w_cntNext   = '0;
            w_stepUp    = 1'b1;
          end else if (w_riseDec && !Exp_increase) begin
            w_stateNext = ST_DELAY;
            w_dirNext   = DIR_DEC;
            w_cntNext   = '0;
            w_stepDn    = 1'b1;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!w_held || w_other) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
          end else if ((r_state == ST_DELAY && (int'(r_cnt) + 2 >= REPEAT_DELAY)) ||
                       (r_state == ST_REPEAT && (int'(r_cnt) + 1 >= REPEAT_RATE))) begin
            w_stateNext = ST_REPEAT;
            w_cntNext   = '0;
            w_stepUp    = (r_dir == DIR_INC);
            w_stepDn    = (r_dir == DIR_DEC);
          end else begin
            w_cntNext = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_exNext = r_exTime;
    if (w_stepUp && r_exTime != MAX_V) begin
      w_exNext = r_exTime + WIDTH'(1);
    end else if (w_stepDn && r_exTime != MIN_V) begin
      w_exNext = r_exTime - WIDTH'(1);
    end
  end

  // Flags are registered from the next value so they always agree with EX_time.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_prevInc <= 1'b0;
      r_prevDec <= 1'b0;
      r_state   <= ST_IDLE;
      r_dir     <= DIR_INC;
      r_cnt     <= '0;
      r_exTime  <= DEF_V;
      r_atMin   <= (DEF_V == MIN_V);
      r_atMax   <= (DEF_V == MAX_V);
      r_changed <= 1'b0;
    end else begin
      r_prevInc <= Exp_increase;
      r_prevDec <= Exp_decrease;
      r_state   <= w_stateNext;
      r_dir     <= w_dirNext;
      r_cnt     <= w_cntNext;
      r_exTime  <= w_exNext;
      r_atMin   <= (w_exNext == MIN_V);
      r_atMax   <= (w_exNext == MAX_V);
      r_changed <= (w_exNext != r_exTime);
    end
  end

  assign EX_time = r_exTime;
  assign At_min  = r_atMin;
  assign At_max  = r_atMax;
  assign Changed = r_changed;

endmodule

// File: tb/tb_ctrl_exposure_time.sv
// Scoreboard bench for ctrl_exposure_time: stimulus queues expected (value, edge) pairs,
// a negedge monitor pops one on every Changed pulse.
module tb_ctrl_exposure_time;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Exp_increase;
  logic       Exp_decrease;
  logic       Lock;
  logic [4:0] EX_time;
  logic       At_min;
  logic       At_max;
  logic       Changed;

  typedef struct {
    int val;
    int atEdge;
  } exp_t;

  exp_t sbQ[$];
  int   edgeCnt = 0;
  int   nChecks = 0;
  int   nErrors = 0;

  ctrl_exposure_time dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Exp_increase (Exp_increase),
    .Exp_decrease (Exp_decrease),
    .Lock         (Lock),
    .EX_time      (EX_time),
    .At_min       (At_min),
    .At_max       (At_max),
    .Changed      (Changed)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) edgeCnt <= edgeCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every Changed pulse must match the oldest queued expectation in value and timing.
  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && Changed) begin
      if (sbQ.size() == 0) begin
        checkOutput("changeExpected", int'(sbQ.size() != 0), 1);
      end else begin
        e = sbQ.pop_front();
        checkOutput("exTime", int'(EX_time), e.val);
        checkOutput("changeEdge", edgeCnt, e.atEdge);
        checkOutput("atMax", int'(At_max), int'(e.val == 30));
        checkOutput("atMin", int'(At_min), int'(e.val == 2));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic expectAt(input int val, input int atEdge);
    exp_t e;
    e.val    = val;
    e.atEdge = atEdge;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit up, input int expVal, input bit expectStep, input int gap);
    if (up) Exp_increase = 1'b1;
    else    Exp_decrease = 1'b1;
    if (expectStep) expectAt(expVal, edgeCnt + 1);
    tick(1);
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    tick(gap);
  endtask

  task automatic checkDrain(input string name, input int expVal);
    tick(3);
    checkOutput({name, "_pending"}, sbQ.size(), 0);
    checkOutput({name, "_value"}, int'(EX_time), expVal);
    sbQ.delete();
  endtask

  task automatic doReset();
    Reset = 1'b1;
    tick(2);
    Reset = 1'b0;
  endtask

  initial begin
    int e0;
    Reset        = 1'b1;
    Exp_increase = 1'b0;
    Exp_decrease = 1'b0;
    Lock         = 1'b0;
    #1;
    checkOutput("rstExTime", int'(EX_time), 10);
    checkOutput("rstAtMin", int'(At_min), 0);
    checkOutput("rstAtMax", int'(At_max), 0);
    checkOutput("rstChanged", int'(Changed), 0);
    tick(2);
    Reset = 1'b0;
    tick(1);

    // Four single-cycle increase pulses, two idle cycles apart
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 11 + i, 1'b1, 2);
    checkDrain("pulses", 14);

    // Simultaneous presses and a press while the other button is held
    Exp_increase = 1'b1; Exp_decrease = 1'b1; tick(3);
    Exp_increase = 1'b0; tick(3);
    Exp_increase = 1'b1; tick(3);
    Exp_increase = 1'b0; Exp_decrease = 1'b0;
    checkDrain("bothButtons", 14);

    // Hold increase for 20 cycles from the default
    doReset();
    tick(1);
    e0 = edgeCnt;
    Exp_increase = 1'b1;
    expectAt(11, e0 + 1);
    expectAt(12, e0 + 8);
    expectAt(13, e0 + 12);
    expectAt(14, e0 + 16);
    expectAt(15, e0 + 20);
    tick(20);
    Exp_increase = 1'b0;
    checkDrain("hold20", 15);

    // Walk to 29, then hold into saturation at the top
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 16 + i, 1'b1, 1);
    e0 = edgeCnt;
    Exp_increase = 1'b1;
    expectAt(30, e0 + 1);
    tick(30);
    Exp_increase = 1'b0;
    checkDrain("satMax", 30);
    checkOutput("satMaxFlag", int'(At_max), 1);

    // Walk down to the bottom and try once more
    doReset();
    tick(1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 9 - i, 1'b1, 1);
    applyStimulus(1'b0, 2, 1'b0, 1);
    checkDrain("satMin", 2);
    checkOutput("satMinFlag", int'(At_min), 1);

    // Lock during auto-repeat stops stepping until the button is pressed again
    doReset();
    tick(1);
    e0 = edgeCnt;
    Exp_increase = 1'b1;
    expectAt(11, e0 + 1);
    expectAt(12, e0 + 8);
    expectAt(13, e0 + 12);
    tick(13);
    Lock = 1'b1;
    tick(3);
    Lock = 1'b0;
    tick(10);
    checkOutput("lockHold", int'(EX_time), 13);
    checkOutput("lockPending", sbQ.size(), 0);
    Exp_increase = 1'b0;
    tick(1);
    applyStimulus(1'b1, 14, 1'b1, 1);
    checkDrain("lockRepress", 14);

    // Asynchronous reset in the middle of a repeat at 20
    doReset();
    tick(1);
    e0 = edgeCnt;
    Exp_increase = 1'b1;
    expectAt(11, e0 + 1);
    expectAt(12, e0 + 8);
    for (int k = 1; k <= 8; k++) expectAt(12 + k, e0 + 8 + 4 * k);
    tick(41);
    checkOutput("preResetValue", int'(EX_time), 20);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("asyncRstExTime", int'(EX_time), 10);
    checkOutput("asyncRstAtMin", int'(At_min), 0);
    checkOutput("asyncRstAtMax", int'(At_max), 0);
    checkOutput("asyncRstChanged", int'(Changed), 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    expectAt(11, edgeCnt + 1);
    tick(2);
    Exp_increase = 1'b0;
    checkDrain("heldThroughReset", 11);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
